// File: rtl/raster_pkg.sv
// Shared encodings for the raster read-address generator: mode codes, FSM states
// and the default accumulator fraction width.
package raster_pkg;

  localparam int unsigned FRAC_W_DEF = 12;

  localparam logic [1:0] MODE_SCALE  = 2'b00;
  localparam logic [1:0] MODE_ZOOM   = 2'b01;
  localparam logic [1:0] MODE_IDENT  = 2'b10;
  localparam logic [1:0] MODE_FREEZE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_RUN  = 2'b10
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. The first bit is resolved in
// the start cycle, so o_done pulses exactly DVD_W cycles after i_start.
module seq_divider #(
  parameter int unsigned DVD_W = 23,
  parameter int unsigned DVS_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [DVD_W-1:0] i_dividend,
  input  logic [DVS_W-1:0] i_divisor,
  output logic             o_done,
  output logic [DVD_W-1:0] o_quot
);

  localparam int unsigned CNT_W = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] r_rem;
  logic [DVD_W-1:0] r_dvd;
  logic [DVS_W-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [DVS_W-1:0] w_src_rem;
  logic [DVD_W-1:0] w_src_dvd;
  logic [DVS_W-1:0] w_src_dvs;
  logic [DVS_W:0]   w_rem_sh;
  logic             w_ge;
  logic [DVS_W-1:0] w_rem_nxt;
  logic [DVD_W-1:0] w_dvd_nxt;

  // One restoring step; the dividend register doubles as the quotient shift register.
  always_comb begin
    w_src_rem = i_start ? '0 : r_rem;
    w_src_dvd = i_start ? i_dividend : r_dvd;
    w_src_dvs = i_start ? i_divisor : r_dvs;
    w_rem_sh  = {w_src_rem, w_src_dvd[DVD_W-1]};
    w_ge      = (w_rem_sh >= {1'b0, w_src_dvs});
    w_rem_nxt = w_ge ? DVS_W'(w_rem_sh - {1'b0, w_src_dvs}) : DVS_W'(w_rem_sh);
    w_dvd_nxt = {w_src_dvd[DVD_W-2:0], w_ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= w_rem_nxt;
        r_dvd  <= w_dvd_nxt;
        r_dvs  <= i_divisor;
        r_cnt  <= CNT_W'(DVD_W - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_rem_nxt;
        r_dvd <= w_dvd_nxt;
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_quot = r_dvd;

endmodule

// File: rtl/raster_addr_gen.sv
// Display-side frame-buffer read-address generator with scale / zoom2x / identity / freeze.
// Optional macro RASTER_PAN_EN adds cfg_pan_x/cfg_pan_y to position the zoom window.
module raster_addr_gen
  import raster_pkg::*;
#(
  parameter int unsigned DST_W     = 640,
  parameter int unsigned DST_H     = 480,
  parameter int unsigned SRC_DIM_W = 11,
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned FRAC_W    = FRAC_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SRC_DIM_W-1:0] cfg_src_w,
  input  logic [SRC_DIM_W-1:0] cfg_src_h,
  input  logic [ADDR_W-1:0]    cfg_stride,
  input  logic [1:0]           cfg_mode,
`ifdef RASTER_PAN_EN
  input  logic [SRC_DIM_W-1:0] cfg_pan_x,
  input  logic [SRC_DIM_W-1:0] cfg_pan_y,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 out_last,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 cfg_err
);

  localparam int unsigned DIV_W     = SRC_DIM_W + FRAC_W;
  localparam int unsigned DVS_W     = $clog2(((DST_W > DST_H) ? DST_W : DST_H) + 1);
  localparam int unsigned CALC_LAST = 2 * DIV_W;
  localparam int unsigned CNT_W     = $clog2(CALC_LAST + 1);
  localparam int unsigned DX_W      = (DST_W > 1) ? $clog2(DST_W) : 1;
  localparam int unsigned DY_W      = (DST_H > 1) ? $clog2(DST_H) : 1;
  localparam int unsigned ACC_W     = DIV_W + ((DX_W > DY_W) ? DX_W : DY_W);
  localparam int unsigned INT_W     = ACC_W - FRAC_W;
  localparam logic [DIV_W-1:0] STEP_ONE = DIV_W'(1) << FRAC_W;

  state_t r_state, w_state_nxt;
  logic   w_latch, w_err;

  logic                 r_shadow_vld;
  logic [SRC_DIM_W-1:0] r_eff_w, r_eff_h, r_org_x, r_org_y;
  logic [ADDR_W-1:0]    r_stride;
  logic [DIV_W-1:0]     r_x_step, r_y_step;
  logic [CNT_W-1:0]     r_calc_cnt;

  logic                 r_primed, r_gen_done;
  logic [DX_W-1:0]      r_dx;
  logic [DY_W-1:0]      r_dy;
  logic [ACC_W-1:0]     r_x_acc, r_y_acc;
  logic [ADDR_W-1:0]    r_row_base;

  logic                 w_cfg_bad;
  logic [SRC_DIM_W-1:0] w_zoom_w, w_zoom_h, w_zoom_ox, w_zoom_oy;
  logic [SRC_DIM_W-1:0] w_cfg_eff_w, w_cfg_eff_h, w_cfg_org_x, w_cfg_org_y;
  logic                 w_div_start, w_div_sel_y, w_div_done;
  logic [DIV_W-1:0]     w_div_dvd, w_div_quot;
  logic [DVS_W-1:0]     w_div_dvs;
  logic [ACC_W-1:0]     w_y_acc_nxt, w_row_y_acc;
  logic [INT_W-1:0]     w_x_int, w_y_int, w_x_lim, w_y_lim;
  logic [ADDR_W-1:0]    w_row_base, w_addr;
  logic                 w_adv, w_load, w_eol, w_eof, w_hs_last;

  // Shadow candidates derived from the live config; a 1-pixel source keeps a 1-pixel window.
  always_comb begin
    w_cfg_bad = (cfg_src_w == '0) || (cfg_src_h == '0) || (cfg_stride < ADDR_W'(cfg_src_w));
    w_zoom_w  = ((cfg_src_w >> 1) == '0) ? SRC_DIM_W'(1) : (cfg_src_w >> 1);
    w_zoom_h  = ((cfg_src_h >> 1) == '0) ? SRC_DIM_W'(1) : (cfg_src_h >> 1);
`ifdef RASTER_PAN_EN
    w_zoom_ox = (cfg_pan_x > cfg_src_w - w_zoom_w) ? (cfg_src_w - w_zoom_w) : cfg_pan_x;
    w_zoom_oy = (cfg_pan_y > cfg_src_h - w_zoom_h) ? (cfg_src_h - w_zoom_h) : cfg_pan_y;
`else
    w_zoom_ox = cfg_src_w >> 2;
    w_zoom_oy = cfg_src_h >> 2;
`endif
    w_cfg_eff_w = (cfg_mode == MODE_ZOOM) ? w_zoom_w  : cfg_src_w;
    w_cfg_eff_h = (cfg_mode == MODE_ZOOM) ? w_zoom_h  : cfg_src_h;
    w_cfg_org_x = (cfg_mode == MODE_ZOOM) ? w_zoom_ox : '0;
    w_cfg_org_y = (cfg_mode == MODE_ZOOM) ? w_zoom_oy : '0;
  end

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (cfg_mode == MODE_FREEZE) begin
            if (r_shadow_vld) w_state_nxt = ST_RUN;
            else              w_err       = 1'b1;
          end else if (w_cfg_bad) begin
            w_err = 1'b1;
          end else begin
            w_latch     = 1'b1;
            w_state_nxt = (cfg_mode == MODE_IDENT) ? ST_RUN : ST_CALC;
          end
        end
      end
      ST_CALC: if (r_calc_cnt == CNT_W'(CALC_LAST)) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_hs_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  // x divide starts on CALC entry, y divide the cycle x completes.
  assign w_div_sel_y = (r_calc_cnt != '0);
  assign w_div_start = (r_state == ST_CALC) &&
                       ((r_calc_cnt == '0) || (r_calc_cnt == CNT_W'(DIV_W)));
  assign w_div_dvd   = w_div_sel_y ? {r_eff_h, FRAC_W'(0)} : {r_eff_w, FRAC_W'(0)};
  assign w_div_dvs   = w_div_sel_y ? DVS_W'(DST_H) : DVS_W'(DST_W);

  seq_divider #(
    .DVD_W (DIV_W),
    .DVS_W (DVS_W)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_div_start),
    .i_dividend (w_div_dvd),
    .i_divisor  (w_div_dvs),
    .o_done     (w_div_done),
    .o_quot     (w_div_quot)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow_vld <= 1'b0;
      r_eff_w      <= '0;
      r_eff_h      <= '0;
      r_org_x      <= '0;
      r_org_y      <= '0;
      r_stride     <= '0;
      r_x_step     <= '0;
      r_y_step     <= '0;
      r_calc_cnt   <= '0;
    end else begin
      r_calc_cnt <= (r_state == ST_CALC) ? r_calc_cnt + CNT_W'(1) : '0;
      if (w_latch) begin
        r_shadow_vld <= 1'b1;
        r_eff_w      <= w_cfg_eff_w;
        r_eff_h      <= w_cfg_eff_h;
        r_org_x      <= w_cfg_org_x;
        r_org_y      <= w_cfg_org_y;
        r_stride     <= cfg_stride;
        r_x_step     <= STEP_ONE;
        r_y_step     <= STEP_ONE;
      end else if (w_div_done) begin
        if (r_calc_cnt == CNT_W'(DIV_W)) r_x_step <= w_div_quot;
        else                             r_y_step <= w_div_quot;
      end
    end
  end

  // Clamped integer source coordinates and address arithmetic.
  always_comb begin
    w_y_acc_nxt = r_y_acc + ACC_W'(r_y_step);
    w_row_y_acc = r_primed ? w_y_acc_nxt : r_y_acc;
    w_x_lim     = INT_W'(r_eff_w) - INT_W'(1);
    w_y_lim     = INT_W'(r_eff_h) - INT_W'(1);
    w_x_int     = (r_x_acc[ACC_W-1:FRAC_W] > w_x_lim) ? w_x_lim : r_x_acc[ACC_W-1:FRAC_W];
    w_y_int     = (w_row_y_acc[ACC_W-1:FRAC_W] > w_y_lim) ? w_y_lim
                                                          : w_row_y_acc[ACC_W-1:FRAC_W];
    w_row_base  = (ADDR_W'(r_org_y) + ADDR_W'(w_y_int)) * r_stride;
    w_addr      = r_row_base + ADDR_W'(r_org_x) + ADDR_W'(w_x_int);
    w_adv       = !out_valid || out_ready;
    w_load      = w_adv && (r_state == ST_RUN) && r_primed && !r_gen_done;
    w_eol       = (r_dx == DX_W'(DST_W - 1));
    w_eof       = w_eol && (r_dy == DY_W'(DST_H - 1));
    w_hs_last   = out_valid && out_ready && out_last;
  end

  // Pixel walker; the first RUN cycle only primes the row base of line 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_primed   <= 1'b0;
      r_gen_done <= 1'b0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_x_acc    <= '0;
      r_y_acc    <= '0;
      r_row_base <= '0;
    end else if (r_state != ST_RUN) begin
      r_primed   <= 1'b0;
      r_gen_done <= 1'b0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_x_acc    <= '0;
      r_y_acc    <= '0;
      r_row_base <= '0;
    end else if (!r_primed) begin
      r_primed   <= 1'b1;
      r_row_base <= w_row_base;
    end else if (w_load) begin
      if (w_eof) begin
        r_gen_done <= 1'b1;
      end else if (w_eol) begin
        r_dx       <= '0;
        r_x_acc    <= '0;
        r_dy       <= r_dy + DY_W'(1);
        r_y_acc    <= w_y_acc_nxt;
        r_row_base <= w_row_base;
      end else begin
        r_dx    <= r_dx + DX_W'(1);
        r_x_acc <= r_x_acc + ACC_W'(r_x_step);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      frame_done <= w_hs_last;
      cfg_err    <= w_err;
      if (r_state != ST_RUN) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (w_adv) begin
        out_valid <= w_load;
        out_last  <= w_load && w_eof;
        if (w_load) out_addr <= w_addr;
      end
    end
  end

endmodule

// File: tb/tb_raster_addr_gen.sv
// Directed bench for raster_addr_gen on a small 16x12 destination raster, with a
// scoreboard queue of expected addresses filled at each frame start.
module tb_raster_addr_gen;
  import raster_pkg::*;

  localparam int unsigned DST_W      = 16;
  localparam int unsigned DST_H      = 12;
  localparam int unsigned SRC_DIM_W  = 11;
  localparam int unsigned ADDR_W     = 19;
  localparam int unsigned FRAC_W     = 12;
  localparam int          LAT_CALC   = 2 * (SRC_DIM_W + FRAC_W) + 1 + 3;
  localparam int          LAT_DIRECT = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              last;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [SRC_DIM_W-1:0] cfg_src_w, cfg_src_h;
  logic [ADDR_W-1:0]    cfg_stride;
  logic [1:0]           cfg_mode;
`ifdef RASTER_PAN_EN
  logic [SRC_DIM_W-1:0] cfg_pan_x = '0;
  logic [SRC_DIM_W-1:0] cfg_pan_y = '0;
`endif
  logic                 out_valid, out_ready, out_last, frame_done, busy, cfg_err;
  logic [ADDR_W-1:0]    out_addr;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t q[$];

  bit m_vld = 1'b0;
  int m_eff_w, m_eff_h, m_org_x, m_org_y, m_stride, m_xs, m_ys;

  always #5 clk = ~clk;

  raster_addr_gen #(
    .DST_W     (DST_W),
    .DST_H     (DST_H),
    .SRC_DIM_W (SRC_DIM_W),
    .ADDR_W    (ADDR_W),
    .FRAC_W    (FRAC_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_src_w  (cfg_src_w),
    .cfg_src_h  (cfg_src_h),
    .cfg_stride (cfg_stride),
    .cfg_mode   (cfg_mode),
`ifdef RASTER_PAN_EN
    .cfg_pan_x  (cfg_pan_x),
    .cfg_pan_y  (cfg_pan_y),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .frame_done (frame_done),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // One clock: score the output at the falling edge, return 1 time unit past the rising edge.
  task automatic tick();
    @(negedge clk);
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 64'(out_valid), 64'(0));
      end else begin
        chk("addr", 64'(out_addr), 64'(q[0].addr));
        chk("last", 64'(out_last), 64'(q[0].last));
        if (out_ready) void'(q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Reference: direct per-pixel formula, steps from integer division of the window size.
  task automatic push_frame(input logic [1:0] mode, input int w, input int h, input int stride);
    int   xi, yi, addr;
    exp_t e;
    if (mode != MODE_FREEZE) begin
      m_eff_w = (mode == MODE_ZOOM) ? ((w / 2 == 0) ? 1 : w / 2) : w;
      m_eff_h = (mode == MODE_ZOOM) ? ((h / 2 == 0) ? 1 : h / 2) : h;
      m_org_x = (mode == MODE_ZOOM) ? w / 4 : 0;
      m_org_y = (mode == MODE_ZOOM) ? h / 4 : 0;
`ifdef RASTER_PAN_EN
      if (mode == MODE_ZOOM) begin
        m_org_x = (int'(cfg_pan_x) > w - m_eff_w) ? w - m_eff_w : int'(cfg_pan_x);
        m_org_y = (int'(cfg_pan_y) > h - m_eff_h) ? h - m_eff_h : int'(cfg_pan_y);
      end
`endif
      m_stride = stride;
      m_xs     = (mode == MODE_IDENT) ? (1 << FRAC_W) : (m_eff_w << FRAC_W) / DST_W;
      m_ys     = (mode == MODE_IDENT) ? (1 << FRAC_W) : (m_eff_h << FRAC_W) / DST_H;
      m_vld    = 1'b1;
    end
    for (int dy = 0; dy < DST_H; dy++) begin
      for (int dx = 0; dx < DST_W; dx++) begin
        xi = (dx * m_xs) >> FRAC_W;
        yi = (dy * m_ys) >> FRAC_W;
        if (xi > m_eff_w - 1) xi = m_eff_w - 1;
        if (yi > m_eff_h - 1) yi = m_eff_h - 1;
        addr   = (m_org_y + yi) * m_stride + m_org_x + xi;
        e.addr = ADDR_W'(addr);
        e.last = (dx == DST_W - 1) && (dy == DST_H - 1);
        q.push_back(e);
      end
    end
  endtask

  task automatic drive_cfg(input logic [1:0] mode, input int w, input int h, input int stride);
    cfg_mode   = mode;
    cfg_src_w  = SRC_DIM_W'(w);
    cfg_src_h  = SRC_DIM_W'(h);
    cfg_stride = ADDR_W'(stride);
  endtask

  task automatic start_frame(input logic [1:0] mode, input int w, input int h, input int stride);
    drive_cfg(mode, w, h, stride);
    push_frame(mode, w, h, stride);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int exp_lat);
    int n = 1;
    chk("busy_after_start", 64'(busy), 64'(1));
    while (out_valid !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("first_valid_latency", 64'(n), 64'(exp_lat));
  endtask

  task automatic drain(input int stall_at, input bit rnd, input int poke);
    int n = 0;
    while (q.size() != 0 && n < 4000) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      else     out_ready = !(stall_at >= 0 && n >= stall_at && n < stall_at + 3);
      if (n == poke) begin
        drive_cfg(MODE_SCALE, 0, 0, 0);
        start = 1'b1;
      end
      tick();
      n++;
      if (start) begin
        start = 1'b0;
        chk("start_in_run_ignored", 64'(cfg_err), 64'(0));
      end
    end
    out_ready = 1'b1;
    chk("frame_drained", 64'(q.size()), 64'(0));
    q.delete();
    chk("frame_done_pulse", 64'(frame_done), 64'(1));
    chk("valid_after_frame", 64'(out_valid), 64'(0));
    chk("busy_after_frame", 64'(busy), 64'(0));
    tick();
    chk("frame_done_single", 64'(frame_done), 64'(0));
  endtask

  task automatic reject(input logic [1:0] mode, input int w, input int h, input int stride);
    drive_cfg(mode, w, h, stride);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cfg_err_pulse", 64'(cfg_err), 64'(1));
    chk("busy_on_reject", 64'(busy), 64'(0));
    tick();
    chk("cfg_err_single", 64'(cfg_err), 64'(0));
    chk("stays_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    drive_cfg(MODE_SCALE, 0, 0, 0);
    repeat (3) tick();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_addr", 64'(out_addr), 64'(0));
    chk("rst_last", 64'(out_last), 64'(0));
    chk("rst_done", 64'(frame_done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(cfg_err), 64'(0));
    reset = 1'b0;
    tick();

    reject(MODE_FREEZE, 16, 12, 16);
    reject(MODE_SCALE, 0, 12, 16);
    reject(MODE_SCALE, 16, 0, 16);
    reject(MODE_ZOOM, 16, 12, 15);

    // Full-size scale, contiguous addresses, 3-cycle stall mid-line.
    start_frame(MODE_SCALE, 16, 12, 16);
    wait_valid(LAT_CALC);
    drain(37, 1'b0, -1);

    // Half-size source: each source pixel and line repeats twice.
    start_frame(MODE_SCALE, 8, 6, 8);
    wait_valid(LAT_CALC);
    drain(-1, 1'b0, -1);

    // Freeze replays the previous frame; live cfg is ignored and CALC is skipped.
    start_frame(MODE_FREEZE, 16, 12, 16);
    wait_valid(LAT_DIRECT);
    drain(-1, 1'b0, 10);

    start_frame(MODE_ZOOM, 16, 12, 16);
    wait_valid(LAT_CALC);
    drain(-1, 1'b1, -1);

    // Identity on a source smaller than the raster: clamping at right and bottom edges.
    start_frame(MODE_IDENT, 10, 8, 20);
    wait_valid(LAT_DIRECT);
    drain(-1, 1'b0, -1);

    start_frame(MODE_SCALE, 13, 7, 13);
    wait_valid(LAT_CALC);
    drain(-1, 1'b1, -1);

    // Asynchronous reset in the middle of a frame.
    start_frame(MODE_SCALE, 16, 12, 16);
    wait_valid(LAT_CALC);
    repeat (20) tick();
    reset = 1'b1;
    #1;
    chk("reset_mid_valid", 64'(out_valid), 64'(0));
    chk("reset_mid_busy", 64'(busy), 64'(0));
    chk("reset_mid_last", 64'(out_last), 64'(0));
    q.delete();
    m_vld = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reject(MODE_FREEZE, 16, 12, 16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
